// File: rtl/ex_stage.sv
// Execute stage: builds operand 2, runs the ALU, owns NZCV and resolves branches.
// Results are captured in an internal EX/MEM register (1-cycle latency).
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic [31:0] pc_in,
   input  logic        wb_en_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        b_in,
   input  logic        s_in,
   input  logic        imm_in,
   input  logic [3:0]  alu_command_in,
   input  logic [31:0] val_rn_in,
   input  logic [31:0] val_rm_in,
   input  logic [11:0] shift_operand_in,
   input  logic [23:0] signed_imm_in,
   input  logic [3:0]  dest_in,
   output logic        branch_taken,
   output logic [31:0] branch_addr,
   output logic [3:0]  status_out,
   output logic        wb_en_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] store_data_out,
   output logic [3:0]  dest_out
);

   typedef enum logic [3:0] {
      OpMov = 4'b0001,
      OpAdd = 4'b0010,
      OpAdc = 4'b0011,
      OpSub = 4'b0100,
      OpSbc = 4'b0101,
      OpAnd = 4'b0110,
      OpOrr = 4'b0111,
      OpEor = 4'b1000,
      OpMvn = 4'b1001
   } alu_op_e;

   logic [3:0]  r_status;
   logic        r_wb_en;
   logic        r_mem_read;
   logic        r_mem_write;
   logic [31:0] r_alu_result;
   logic [31:0] r_store_data;
   logic [3:0]  r_dest;

   logic        w_mem_access;
   logic [31:0] w_imm32;
   logic [63:0] w_imm_rot;
   logic [63:0] w_rm_rot;
   logic [4:0]  w_amt;
   logic [31:0] w_val2;
   logic [3:0]  w_cmd;
   logic        w_cin;
   logic [32:0] w_sum;
   logic [31:0] w_res;
   logic        w_c;
   logic        w_v;
   logic [3:0]  w_flags;

   assign branch_taken = b_in;
   assign branch_addr  = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};

   assign w_mem_access = mem_read_in | mem_write_in;
   assign w_imm32      = {24'b0, shift_operand_in[7:0]};
   assign w_imm_rot    = {w_imm32, w_imm32} >> {shift_operand_in[11:8], 1'b0};
   assign w_amt        = shift_operand_in[11:7];
   assign w_rm_rot     = {val_rm_in, val_rm_in} >> w_amt;

   always_comb begin
      w_val2 = val_rm_in;
      if (imm_in) begin
         w_val2 = w_imm_rot[31:0];
      end else if (w_mem_access) begin
         w_val2 = {20'b0, shift_operand_in};
      end else begin
         case (shift_operand_in[6:5])
            2'b00:   w_val2 = val_rm_in << w_amt;
            2'b01:   w_val2 = val_rm_in >> w_amt;
            2'b10:   w_val2 = $signed(val_rm_in) >>> w_amt;
            default: w_val2 = w_rm_rot[31:0];
         endcase
      end
   end

   // Loads and stores compute their address with ADD regardless of the opcode.
   assign w_cmd = w_mem_access ? OpAdd : alu_command_in;
   assign w_cin = r_status[1];

   always_comb begin
      w_sum = 33'd0;
      w_res = 32'd0;
      w_c   = w_cin;
      w_v   = r_status[0];
      case (w_cmd)
         OpMov: w_res = w_val2;
         OpMvn: w_res = ~w_val2;
         OpAdd, OpAdc: begin
            w_sum = {1'b0, val_rn_in} + {1'b0, w_val2}
                    + {32'b0, (w_cmd == OpAdc) & w_cin};
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = (val_rn_in[31] == w_val2[31]) && (w_res[31] != val_rn_in[31]);
         end
         OpSub, OpSbc: begin
            // rn + ~val2 + 1 (or + C for SBC); carry out is the no-borrow flag.
            w_sum = {1'b0, val_rn_in} + {1'b0, ~w_val2}
                    + {32'b0, (w_cmd == OpSbc) ? w_cin : 1'b1};
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = (val_rn_in[31] != w_val2[31]) && (w_res[31] != val_rn_in[31]);
         end
         OpAnd: w_res = val_rn_in & w_val2;
         OpOrr: w_res = val_rn_in | w_val2;
         OpEor: w_res = val_rn_in ^ w_val2;
         default: begin
            w_res = 32'd0;
            w_v   = 1'b0;
         end
      endcase
   end

   assign w_flags = {w_res[31], (w_res == 32'd0), w_c, w_v};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= 4'd0;
      end else if (s_in && !freeze) begin
         r_status <= w_flags;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_en      <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_alu_result <= 32'd0;
         r_store_data <= 32'd0;
         r_dest       <= 4'd0;
      end else if (!freeze) begin
         r_wb_en      <= wb_en_in;
         r_mem_read   <= mem_read_in;
         r_mem_write  <= mem_write_in;
         r_alu_result <= w_res;
         r_store_data <= val_rm_in;
         r_dest       <= dest_in;
      end
   end

   assign status_out     = r_status;
   assign wb_en_out      = r_wb_en;
   assign mem_read_out   = r_mem_read;
   assign mem_write_out  = r_mem_write;
   assign alu_result_out = r_alu_result;
   assign store_data_out = r_store_data;
   assign dest_out       = r_dest;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of instructions with hand-derived results, plus freeze,
// branch and asynchronous-reset sequences; expectations go through a scoreboard queue.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic [31:0] pc_in;
   logic        wb_en_in, mem_read_in, mem_write_in, b_in, s_in, imm_in;
   logic [3:0]  alu_command_in;
   logic [31:0] val_rn_in, val_rm_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm_in;
   logic [3:0]  dest_in;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  status_out;
   logic        wb_en_out, mem_read_out, mem_write_out;
   logic [31:0] alu_result_out, store_data_out;
   logic [3:0]  dest_out;

   ex_stage u_dut (
      .clk              (clk),
      .rst              (rst),
      .freeze           (freeze),
      .pc_in            (pc_in),
      .wb_en_in         (wb_en_in),
      .mem_read_in      (mem_read_in),
      .mem_write_in     (mem_write_in),
      .b_in             (b_in),
      .s_in             (s_in),
      .imm_in           (imm_in),
      .alu_command_in   (alu_command_in),
      .val_rn_in        (val_rn_in),
      .val_rm_in        (val_rm_in),
      .shift_operand_in (shift_operand_in),
      .signed_imm_in    (signed_imm_in),
      .dest_in          (dest_in),
      .branch_taken     (branch_taken),
      .branch_addr      (branch_addr),
      .status_out       (status_out),
      .wb_en_out        (wb_en_out),
      .mem_read_out     (mem_read_out),
      .mem_write_out    (mem_write_out),
      .alu_result_out   (alu_result_out),
      .store_data_out   (store_data_out),
      .dest_out         (dest_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic        imm, mr, mw, wb, s;
      logic [31:0] rn, rm;
      logic [11:0] so;
      logic [3:0]  dest;
      logic [31:0] exp_res;
      logic [3:0]  exp_st;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  st;
      logic        wb, mr, mw;
      logic [31:0] sd;
      logic [3:0]  dest;
   } exp_t;

   vec_t tbl[17];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      alu_command_in   = v.cmd;
      imm_in           = v.imm;
      mem_read_in      = v.mr;
      mem_write_in     = v.mw;
      wb_en_in         = v.wb;
      s_in             = v.s;
      val_rn_in        = v.rn;
      val_rm_in        = v.rm;
      shift_operand_in = v.so;
      dest_in          = v.dest;
   endtask

   function automatic exp_t mk_exp(input vec_t v);
      exp_t e;
      e.res  = v.exp_res;
      e.st   = v.exp_st;
      e.wb   = v.wb;
      e.mr   = v.mr;
      e.mw   = v.mw;
      e.sd   = v.rm;
      e.dest = v.dest;
      return e;
   endfunction

   task automatic check_out(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " result"}, alu_result_out, e.res);
         chk({tag, " status"}, {28'd0, status_out}, {28'd0, e.st});
         chk({tag, " ctrl"}, {29'd0, wb_en_out, mem_read_out, mem_write_out},
             {29'd0, e.wb, e.mr, e.mw});
         chk({tag, " store_data"}, store_data_out, e.sd);
         chk({tag, " dest"}, {28'd0, dest_out}, {28'd0, e.dest});
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " result"}, alu_result_out, 32'd0);
      chk({tag, " status"}, {28'd0, status_out}, 32'd0);
      chk({tag, " ctrl"}, {29'd0, wb_en_out, mem_read_out, mem_write_out}, 32'd0);
      chk({tag, " store_data"}, store_data_out, 32'd0);
      chk({tag, " dest"}, {28'd0, dest_out}, 32'd0);
   endtask

   initial begin
      vec_t v;
      // cmd imm mr mw wb s rn rm so dest exp_res exp_st
      tbl[0]  = '{4'b0010, 1, 0, 0, 1, 1, 32'h7FFFFFFF, 32'h0, 12'h001, 4'd1, 32'h80000000, 4'b1001};
      tbl[1]  = '{4'b0001, 1, 0, 0, 1, 1, 32'h0, 32'h0, 12'h4FF, 4'd2, 32'hFF000000, 4'b1001};
      tbl[2]  = '{4'b0100, 1, 0, 0, 1, 1, 32'h5, 32'h0, 12'h005, 4'd3, 32'h00000000, 4'b0110};
      tbl[3]  = '{4'b0010, 1, 0, 0, 1, 1, 32'h1, 32'h0, 12'h001, 4'd4, 32'h00000002, 4'b0000};
      tbl[4]  = '{4'b0101, 1, 0, 0, 1, 1, 32'h5, 32'h0, 12'h005, 4'd5, 32'hFFFFFFFF, 4'b1000};
      tbl[5]  = '{4'b0010, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'h1, 12'h000, 4'd6, 32'h0, 4'b0110};
      tbl[6]  = '{4'b0011, 0, 0, 0, 1, 1, 32'h1, 32'h2, 12'h000, 4'd7, 32'h4, 4'b0000};
      tbl[7]  = '{4'b0111, 0, 0, 0, 1, 1, 32'h0, 32'h80000000, 12'h240, 4'd8, 32'hF8000000, 4'b1000};
      tbl[8]  = '{4'b1000, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hF1, 12'h260, 4'd9, 32'hEFFFFFF0, 4'b1000};
      tbl[9]  = '{4'b0110, 0, 0, 0, 1, 1, 32'hFFFF0000, 32'hF0F00000, 12'h420, 4'd10, 32'h00F00000,
                  4'b0000};
      tbl[10] = '{4'b0100, 0, 1, 0, 1, 0, 32'h100, 32'h0, 12'h004, 4'd11, 32'h104, 4'b0000};
      tbl[11] = '{4'b0001, 0, 0, 1, 0, 0, 32'h200, 32'hDEADBEEF, 12'hFFC, 4'd12, 32'h11FC, 4'b0000};
      tbl[12] = '{4'b1001, 1, 0, 0, 1, 1, 32'h0, 32'h0, 12'h000, 4'd13, 32'hFFFFFFFF, 4'b1000};
      tbl[13] = '{4'b0000, 0, 0, 0, 1, 1, 32'h1234, 32'h55, 12'h000, 4'd14, 32'h0, 4'b0100};
      tbl[14] = '{4'b0100, 0, 0, 0, 1, 1, 32'h3, 32'h5, 12'h000, 4'd15, 32'hFFFFFFFE, 4'b1000};
      tbl[15] = '{4'b0100, 1, 0, 0, 1, 1, 32'h80000000, 32'h0, 12'h001, 4'd1, 32'h7FFFFFFF, 4'b0011};
      tbl[16] = '{4'b1111, 0, 0, 0, 1, 1, 32'h9, 32'h9, 12'h000, 4'd2, 32'h0, 4'b0110};

      rst = 1'b1;
      freeze = 1'b0;
      b_in = 1'b0;
      pc_in = 32'h0;
      signed_imm_in = 24'h0;
      drive('{4'b0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 12'h0, 4'd0, 32'h0, 4'b0});
      #3;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         exp_q.push_back(mk_exp(tbl[i]));
         #1;
         chk($sformatf("vec%0d branch_taken", i), {31'd0, branch_taken}, 32'd0);
         @(posedge clk);
         #1;
         check_out($sformatf("vec%0d", i));
      end

      // Branch resolution is combinational and ignores freeze.
      @(negedge clk);
      freeze = 1'b1;
      b_in = 1'b1;
      pc_in = 32'h20;
      signed_imm_in = 24'hFFFFFE;
      #1;
      chk("branch_taken", {31'd0, branch_taken}, 32'd1);
      chk("branch_addr back", branch_addr, 32'h18);
      pc_in = 32'hFFFFFFFC;
      signed_imm_in = 24'h000002;
      #1;
      chk("branch_addr wrap", branch_addr, 32'h4);
      b_in = 1'b0;

      // Freeze for two edges with s_in set: EX/MEM and status hold tbl[16] results.
      v = '{4'b0010, 1, 0, 0, 1, 1, 32'h1, 32'hA5A5, 12'h001, 4'd7, 32'h2, 4'b0000};
      drive(v);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("freeze%0d result", k), alu_result_out, 32'h0);
         chk($sformatf("freeze%0d status", k), {28'd0, status_out}, 32'h6);
         chk($sformatf("freeze%0d dest", k), {28'd0, dest_out}, 32'd2);
      end
      @(negedge clk);
      freeze = 1'b0;
      exp_q.push_back(mk_exp(v));
      @(posedge clk);
      #1;
      check_out("unfreeze");

      // Asynchronous reset mid-cycle after loading nonzero state.
      @(negedge clk);
      drive(tbl[12]);
      exp_q.push_back(mk_exp(tbl[12]));
      @(posedge clk);
      #1;
      check_out("pre_reset");
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      check_all_zero("reset_held");
      @(negedge clk);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
